// File: rtl/frame_scroll_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_scroll_ctrl_if
// Brief    : Config valid/ready port for the frame scroll controller.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_scroll_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_speed;
    logic       cfg_dir;
    logic       cfg_pause;
    logic       cfg_step;

    modport master (
        output cfg_valid, cfg_speed, cfg_dir, cfg_pause, cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_speed, cfg_dir, cfg_pause, cfg_step,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/frame_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_scroll_ctrl
// Brief    : Frame-synchronous horizontal scroll controller. Config is held in
//            a shadow register and applied on the vsync leading edge.
//            Optional macro SCROLL_STEP_EN adds a single-step STEP state.
// Revision : 1.0 - initial release
// ============================================================================
module frame_scroll_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter bit VSYNC_ACT = 1'b0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           vsync,
    frame_scroll_ctrl_if.slave  cfg,
    output logic [10:0]         x_offset,
    output logic                frame_tick,
    output logic [7:0]          frame_count,
    output logic                paused
);

    localparam logic [11:0] C_H_ACTIVE = 12'(H_ACTIVE);

    typedef enum logic [1:0] {
        S_RUNNING = 2'd0,
        S_PAUSED  = 2'd1,
        S_STEP    = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_vsync_q;
    logic [3:0]  r_speed;
    logic        r_dir;
    logic        r_pause;
    logic [3:0]  r_sh_speed;
    logic        r_sh_dir;
    logic        r_sh_pause;
    logic        r_pending;
    logic [10:0] r_x_offset;
    logic        r_frame_tick;
    logic [7:0]  r_frame_count;
    logic        r_paused;

    logic        w_edge;
    logic        w_hs;
    logic [3:0]  w_speed;
    logic        w_dir;
    logic        w_pause;
    logic        w_advance;
    logic [11:0] w_fwd_sum;
    logic [11:0] w_fwd;
    logic [11:0] w_rev;
    logic [11:0] w_next;
    logic        w_unused_msb;

`ifdef SCROLL_STEP_EN
    logic        r_sh_step;
    logic        w_step;
    assign w_step = r_pending & r_sh_step;
`else
    logic        w_unused_step;
    assign w_unused_step = cfg.cfg_step;
`endif

    assign w_edge = (vsync == VSYNC_ACT) && (r_vsync_q != VSYNC_ACT);
    assign w_hs   = cfg.cfg_valid && !r_pending;

    // Values that become active at this edge: the shadow wins when pending
    assign w_speed = r_pending ? r_sh_speed : r_speed;
    assign w_dir   = r_pending ? r_sh_dir   : r_dir;
    assign w_pause = r_pending ? r_sh_pause : r_pause;

    assign w_advance = !w_pause || (r_state == S_STEP);

    assign w_fwd_sum = {1'b0, r_x_offset} + {8'd0, w_speed};
    assign w_fwd     = (w_fwd_sum >= C_H_ACTIVE) ? (w_fwd_sum - C_H_ACTIVE) : w_fwd_sum;
    assign w_rev     = ({1'b0, r_x_offset} < {8'd0, w_speed})
                     ? ({1'b0, r_x_offset} + C_H_ACTIVE - {8'd0, w_speed})
                     : ({1'b0, r_x_offset} - {8'd0, w_speed});
    assign w_next       = w_dir ? w_rev : w_fwd;
    assign w_unused_msb = w_next[11];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUNNING;
            r_vsync_q     <= !VSYNC_ACT;
            r_speed       <= 4'd1;
            r_dir         <= 1'b0;
            r_pause       <= 1'b0;
            r_sh_speed    <= 4'd0;
            r_sh_dir      <= 1'b0;
            r_sh_pause    <= 1'b0;
`ifdef SCROLL_STEP_EN
            r_sh_step     <= 1'b0;
`endif
            r_pending     <= 1'b0;
            r_x_offset    <= 11'd0;
            r_frame_tick  <= 1'b0;
            r_frame_count <= 8'd0;
            r_paused      <= 1'b0;
        end else begin
            r_vsync_q    <= vsync;
            r_frame_tick <= w_edge;

            // A handshake in the edge cycle is only possible when nothing was
            // pending, so it is kept for the next frame.
            if (w_hs) begin
                r_sh_speed <= cfg.cfg_speed;
                r_sh_dir   <= cfg.cfg_dir;
                r_sh_pause <= cfg.cfg_pause;
`ifdef SCROLL_STEP_EN
                r_sh_step  <= cfg.cfg_step;
`endif
                r_pending  <= 1'b1;
            end else if (w_edge) begin
                r_pending  <= 1'b0;
            end

            if (w_edge) begin
                r_frame_count <= r_frame_count + 8'd1;
                r_speed       <= w_speed;
                r_dir         <= w_dir;
                r_pause       <= w_pause;
                if (w_advance) begin
                    r_x_offset <= w_next[10:0];
                end
                if (!w_pause) begin
                    r_state  <= S_RUNNING;
                    r_paused <= 1'b0;
`ifdef SCROLL_STEP_EN
                end else if (r_state == S_PAUSED && w_step) begin
                    r_state  <= S_STEP;
                    r_paused <= 1'b0;
`endif
                end else begin
                    r_state  <= S_PAUSED;
                    r_paused <= 1'b1;
                end
            end
        end
    end

    assign cfg.cfg_ready = !r_pending;
    assign x_offset      = r_x_offset;
    assign frame_tick    = r_frame_tick;
    assign frame_count   = r_frame_count;
    assign paused        = r_paused;

endmodule
`default_nettype wire
